// File: rtl/cond_unit_mctx.sv
// Multi-context conditional-execution unit: banked NZCV flags with shadow copies,
// qualified condition decode, gated write enables and a saturating fail counter.
module cond_unit_mctx #(
  parameter int NUM_CTX = 4,
  parameter int CTRL_W = 3,
  parameter int CNT_W = 16,
  localparam int CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              Valid,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [CTX_W-1:0]  Ctx,
  input  logic [3:0]        Cond,
  input  logic [3:0]        ALUFlags,
  input  logic [1:0]        FlagW,
  input  logic              PCS,
  input  logic              NoWrite,
  input  logic [CTRL_W-1:0] CtrlIn,
  input  logic              Save,
  input  logic              Restore,
  input  logic [CTX_W-1:0]  SRCtx,
  input  logic              CntClr,
  output logic              CondEx,
  output logic              PCSrc,
  output logic [CTRL_W-1:0] CtrlOut,
  output logic [3:0]        FlagsOut,
  output logic [CNT_W-1:0]  FailCnt
);

  logic [3:0]       live_r [NUM_CTX];
  logic [3:0]       shadow_r [NUM_CTX];
  logic [3:0]       live_nxt_s [NUM_CTX];
  logic [3:0]       shadow_nxt_s [NUM_CTX];
  logic [CTX_W-1:0] ctx_s;
  logic [CTX_W-1:0] src_s;
  logic [3:0]       flags_s;
  logic             raw_s;
  logic             qual_s;
  logic             fail_s;
  logic [CNT_W-1:0] cnt_r;

  // Out-of-range context numbers alias onto context 0.
  assign ctx_s   = (int'(Ctx) < NUM_CTX) ? Ctx : {CTX_W{1'b0}};
  assign src_s   = (int'(SRCtx) < NUM_CTX) ? SRCtx : {CTX_W{1'b0}};
  assign flags_s = live_r[ctx_s];

  // Condition decode against the live {N,Z,C,V} of the executing context.
  always_comb begin
    raw_s = 1'b0;
    case (Cond)
      4'b0000: raw_s = flags_s[2];
      4'b0001: raw_s = ~flags_s[2];
      4'b0010: raw_s = flags_s[1];
      4'b0011: raw_s = ~flags_s[1];
      4'b0100: raw_s = flags_s[3];
      4'b0101: raw_s = ~flags_s[3];
      4'b0110: raw_s = flags_s[0];
      4'b0111: raw_s = ~flags_s[0];
      4'b1000: raw_s = flags_s[1] & ~flags_s[2];
      4'b1001: raw_s = ~flags_s[1] | flags_s[2];
      4'b1010: raw_s = (flags_s[3] == flags_s[0]);
      4'b1011: raw_s = (flags_s[3] != flags_s[0]);
      4'b1100: raw_s = ~flags_s[2] & (flags_s[3] == flags_s[0]);
      4'b1101: raw_s = flags_s[2] | (flags_s[3] != flags_s[0]);
      4'b1110: raw_s = 1'b1;
      default: raw_s = 1'b0;
    endcase
  end

  // RESETn in the qualifier holds every decision low during reset.
  assign qual_s   = Valid & ~Flush & ~Stall & RESETn;
  assign fail_s   = qual_s & ~raw_s;
  assign CondEx   = raw_s & qual_s;
  assign PCSrc    = CondEx & PCS;
  assign FlagsOut = flags_s;
  assign FailCnt  = cnt_r;

  // Write-enable gating; bit 0 (register write) is also killed by NoWrite.
  always_comb begin
    CtrlOut    = CtrlIn & {CTRL_W{CondEx}};
    CtrlOut[0] = CtrlOut[0] & ~NoWrite;
  end

  // Per-bank next state: instruction update first, then Restore overrides it.
  always_comb begin
    for (int i = 0; i < NUM_CTX; i++) begin
      live_nxt_s[i][3:2] = (CondEx && FlagW[1] && (ctx_s == CTX_W'(i)))
                           ? ALUFlags[3:2] : live_r[i][3:2];
      live_nxt_s[i][1:0] = (CondEx && FlagW[0] && (ctx_s == CTX_W'(i)))
                           ? ALUFlags[1:0] : live_r[i][1:0];
      live_nxt_s[i]      = (Restore && (src_s == CTX_W'(i))) ? shadow_r[i] : live_nxt_s[i];
      shadow_nxt_s[i]    = (Save && (src_s == CTX_W'(i))) ? live_r[i] : shadow_r[i];
    end
  end

  // Live and shadow flag banks.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        live_r[i]   <= 4'b0000;
        shadow_r[i] <= 4'b0000;
      end
    end else begin
      for (int i = 0; i < NUM_CTX; i++) begin
        live_r[i]   <= live_nxt_s[i];
        shadow_r[i] <= shadow_nxt_s[i];
      end
    end
  end

  // Saturating condition-fail counter; clear dominates increment.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (CntClr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (fail_s && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_cond_unit_mctx.sv
// Directed bench for cond_unit_mctx (3 contexts, 2-bit counter); a reference model
// queues expected outputs per step and they are popped and checked mid-cycle.
module tb_cond_unit_mctx;

  logic       CLK = 1'b0;
  logic       RESETn;
  logic       Valid, Stall, Flush, PCS, NoWrite, Save, Restore, CntClr;
  logic [1:0] Ctx, SRCtx, FlagW;
  logic [3:0] Cond, ALUFlags;
  logic [2:0] CtrlIn;
  logic       CondEx, PCSrc;
  logic [2:0] CtrlOut;
  logic [3:0] FlagsOut;
  logic [1:0] FailCnt;

  typedef struct packed {
    logic       condex;
    logic       pcsrc;
    logic [2:0] ctrl;
    logic [3:0] flags;
    logic [1:0] cnt;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] mf [3];
  logic [3:0] msh [3];
  int         mcnt;
  int         n_assert = 0;
  int         n_fail = 0;

  cond_unit_mctx #(.NUM_CTX(3), .CTRL_W(3), .CNT_W(2)) dut (
    .CLK(CLK), .RESETn(RESETn), .Valid(Valid), .Stall(Stall), .Flush(Flush),
    .Ctx(Ctx), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS),
    .NoWrite(NoWrite), .CtrlIn(CtrlIn), .Save(Save), .Restore(Restore),
    .SRCtx(SRCtx), .CntClr(CntClr), .CondEx(CondEx), .PCSrc(PCSrc),
    .CtrlOut(CtrlOut), .FlagsOut(FlagsOut), .FailCnt(FailCnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Condition evaluated from pairs: even code is the base test, odd code its inverse.
  function automatic logic raw_model(input logic [3:0] cond, input logic [3:0] f);
    logic base;
    case (cond[3:1])
      3'd0: base = f[2];
      3'd1: base = f[1];
      3'd2: base = f[3];
      3'd3: base = f[0];
      3'd4: base = f[1] & ~f[2];
      3'd5: base = (f[3] == f[0]);
      3'd6: base = ~f[2] & (f[3] == f[0]);
      default: base = 1'b1;
    endcase
    return cond[0] ? ~base : base;
  endfunction

  task automatic idle();
    Valid = 1'b0; Stall = 1'b0; Flush = 1'b0; Ctx = 2'd0; Cond = 4'b1111;
    ALUFlags = 4'b0000; FlagW = 2'b00; PCS = 1'b0; NoWrite = 1'b0; CtrlIn = 3'b000;
    Save = 1'b0; Restore = 1'b0; SRCtx = 2'd0; CntClr = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mf[i] = 4'b0000;
      msh[i] = 4'b0000;
    end
    mcnt = 0;
  endtask

  // One clock: predict, push, check mid-cycle, advance the model across the edge.
  task automatic step();
    int c, s;
    logic q, r, ex;
    exp_t e, got;
    logic [3:0] nl [3];
    logic [3:0] ns [3];
    c = (Ctx >= 2'd3) ? 0 : int'(Ctx);
    s = (SRCtx >= 2'd3) ? 0 : int'(SRCtx);
    q = Valid & ~Flush & ~Stall;
    r = raw_model(Cond, mf[c]);
    ex = q & r;
    e.condex = ex;
    e.pcsrc = ex & PCS;
    e.ctrl = ex ? {CtrlIn[2:1], CtrlIn[0] & ~NoWrite} : 3'b000;
    e.flags = mf[c];
    e.cnt = 2'(mcnt);
    sb.push_back(e);
    #3;
    got = sb.pop_front();
    chk("condex", {31'd0, CondEx}, {31'd0, got.condex});
    chk("pcsrc", {31'd0, PCSrc}, {31'd0, got.pcsrc});
    chk("ctrlout", {29'd0, CtrlOut}, {29'd0, got.ctrl});
    chk("flagsout", {28'd0, FlagsOut}, {28'd0, got.flags});
    chk("failcnt", {30'd0, FailCnt}, {30'd0, got.cnt});
    for (int i = 0; i < 3; i++) begin
      nl[i] = mf[i];
      ns[i] = msh[i];
    end
    if (ex && FlagW[1]) nl[c][3:2] = ALUFlags[3:2];
    if (ex && FlagW[0]) nl[c][1:0] = ALUFlags[1:0];
    if (Save) ns[s] = mf[s];
    if (Restore) nl[s] = msh[s];
    if (CntClr) mcnt = 0;
    else if (q && !r && mcnt < 3) mcnt = mcnt + 1;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) begin
      mf[i] = nl[i];
      msh[i] = ns[i];
    end
  endtask

  task automatic go(input logic [1:0] ctx, input logic [3:0] cond,
                    input logic [1:0] fw, input logic [3:0] alu);
    Valid = 1'b1; Ctx = ctx; Cond = cond; FlagW = fw; ALUFlags = alu;
    step();
    idle();
  endtask

  task automatic peek(input string tag, input logic [1:0] ctx, input logic [3:0] expv);
    Ctx = ctx;
    #1;
    chk(tag, {28'd0, FlagsOut}, {28'd0, expv});
    Ctx = 2'd0;
  endtask

  initial begin
    idle();
    model_reset();
    RESETn = 1'b0;
    Valid = 1'b1; Cond = 4'b1110; PCS = 1'b1; CtrlIn = 3'b111;
    #2;
    chk("rst_condex", {31'd0, CondEx}, 32'd0);
    chk("rst_pcsrc", {31'd0, PCSrc}, 32'd0);
    chk("rst_ctrl", {29'd0, CtrlOut}, 32'd0);
    chk("rst_flags", {28'd0, FlagsOut}, 32'd0);
    chk("rst_cnt", {30'd0, FailCnt}, 32'd0);
    idle();
    RESETn = 1'b1;
    @(posedge CLK);
    #1;

    go(2'd0, 4'b0000, 2'b00, 4'b0000);
    chk("cnt_first_fail", {30'd0, FailCnt}, 32'd1);
    PCS = 1'b1; NoWrite = 1'b1; CtrlIn = 3'b111;
    go(2'd0, 4'b1110, 2'b00, 4'b0000);
    CtrlIn = 3'b011;
    go(2'd0, 4'b1110, 2'b00, 4'b0000);

    go(2'd1, 4'b1110, 2'b11, 4'b0100);
    peek("ctx1_z_set", 2'd1, 4'b0100);
    go(2'd1, 4'b0000, 2'b00, 4'b0000);
    go(2'd0, 4'b0000, 2'b00, 4'b0000);

    go(2'd2, 4'b1110, 2'b01, 4'b0010);
    go(2'd2, 4'b1110, 2'b10, 4'b1111);
    peek("nz_only_update", 2'd2, 4'b1110);
    go(2'd2, 4'b1000, 2'b00, 4'b0000);
    chk("cnt_three", {30'd0, FailCnt}, 32'd3);
    CntClr = 1'b1;
    go(2'd0, 4'b1111, 2'b00, 4'b0000);
    chk("cnt_clr", {30'd0, FailCnt}, 32'd0);

    go(2'd2, 4'b1110, 2'b11, 4'b1000);
    Save = 1'b1; SRCtx = 2'd2; step(); idle();
    go(2'd2, 4'b1110, 2'b11, 4'b0001);
    peek("after_update", 2'd2, 4'b0001);
    Restore = 1'b1; SRCtx = 2'd2; step(); idle();
    peek("restored", 2'd2, 4'b1000);

    go(2'd2, 4'b1110, 2'b11, 4'b0011);
    Save = 1'b1; Restore = 1'b1; SRCtx = 2'd2; step(); idle();
    peek("swap_live", 2'd2, 4'b1000);
    Restore = 1'b1; SRCtx = 2'd2; step(); idle();
    peek("swap_shadow", 2'd2, 4'b0011);

    go(2'd2, 4'b1110, 2'b11, 4'b0110);
    Restore = 1'b1; SRCtx = 2'd2;
    go(2'd2, 4'b1110, 2'b11, 4'b1111);
    peek("restore_wins", 2'd2, 4'b0011);

    go(2'd2, 4'b1110, 2'b11, 4'b1100);
    Restore = 1'b1; SRCtx = 2'd2;
    go(2'd1, 4'b1110, 2'b11, 4'b1010);
    peek("diff_ctx_upd", 2'd1, 4'b1010);
    peek("diff_ctx_rst", 2'd2, 4'b0011);

    Stall = 1'b1; PCS = 1'b1; CtrlIn = 3'b111;
    go(2'd1, 4'b1110, 2'b11, 4'b0101);
    Flush = 1'b1; PCS = 1'b1; CtrlIn = 3'b111;
    go(2'd1, 4'b1110, 2'b11, 4'b0101);
    Stall = 1'b1;
    go(2'd0, 4'b1111, 2'b00, 4'b0000);
    peek("stall_hold", 2'd1, 4'b1010);

    go(2'd3, 4'b1110, 2'b11, 4'b0110);
    peek("ctx_alias", 2'd0, 4'b0110);
    Save = 1'b1; SRCtx = 2'd3; step(); idle();
    go(2'd0, 4'b1110, 2'b11, 4'b0000);
    Restore = 1'b1; SRCtx = 2'd3; step(); idle();
    peek("srctx_alias", 2'd0, 4'b0110);

    for (int k = 0; k < 16; k++) begin
      go(2'd0, 4'(k), 2'b00, 4'b0000);
      go(2'd1, 4'(k), 2'b00, 4'b0000);
      go(2'd2, 4'(k), 2'b00, 4'b0000);
    end

    CntClr = 1'b1; step(); idle();
    for (int k = 1; k <= 4; k++) begin
      go(2'd0, 4'b1111, 2'b00, 4'b0000);
      chk("cnt_sat", {30'd0, FailCnt}, (k > 3) ? 32'd3 : 32'(k));
    end
    CntClr = 1'b1;
    go(2'd0, 4'b1111, 2'b00, 4'b0000);
    chk("cnt_clr_prio", {30'd0, FailCnt}, 32'd0);
    go(2'd0, 4'b0000, 2'b00, 4'b0000);

    Valid = 1'b1; Ctx = 2'd1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1111;
    PCS = 1'b1; CtrlIn = 3'b111;
    #2;
    RESETn = 1'b0;
    #1;
    chk("midrst_condex", {31'd0, CondEx}, 32'd0);
    chk("midrst_pcsrc", {31'd0, PCSrc}, 32'd0);
    chk("midrst_ctrl", {29'd0, CtrlOut}, 32'd0);
    chk("midrst_flags", {28'd0, FlagsOut}, 32'd0);
    chk("midrst_cnt", {30'd0, FailCnt}, 32'd0);
    @(posedge CLK);
    #1;
    idle();
    model_reset();
    RESETn = 1'b1;
    peek("post_rst_ctx1", 2'd1, 4'b0000);
    go(2'd1, 4'b0000, 2'b00, 4'b0000);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cond_unit_mctx.md
# cond_unit_mctx

Multi-context conditional-execution unit for the Execute stage of the pipelined ARM-subset core. It generalises the single-bank condition check to NUM_CTX banked NZCV flag sets and a CTRL_W-bit vector of gated write enables. It adds pipeline stall/flush qualification, per-context shadow flags for exception save/restore, and a saturating condition-fail counter. Commit decisions leave combinationally in the same cycle; flag state updates on the clock edge.

## Interface
Parameters:
- NUM_CTX, 4, number of flag contexts (1..16); CTX_W = max(1, clog2(NUM_CTX)) derived locally
- CTRL_W, 3, width of gated write-enable vector (>=1)
- CNT_W, 16, width of fail counter

Ports:
- CLK  in  1  clock, all state on rising edge
- RESETn  in  1  asynchronous active-low reset
- Valid  in  1  Execute holds a real instruction (0 = bubble)
- Stall  in  1  Execute held this cycle
- Flush  in  1  instruction in Execute squashed
- Ctx  in  CTX_W  context of executing instruction
- Cond  in  4  condition field
- ALUFlags  in  4  {N,Z,C,V} from ALU
- FlagW  in  2  [1] update N,Z; [0] update C,V
- PCS  in  1  instruction writes PC
- NoWrite  in  1  suppresses CtrlIn[0] (register write, e.g. CMP)
- CtrlIn  in  CTRL_W  raw write enables; [0] RegW, [1] MemW, rest user-defined
- Save  in  1  copy live flags of SRCtx into its shadow
- Restore  in  1  copy shadow of SRCtx into its live flags
- SRCtx  in  CTX_W  context targeted by Save/Restore
- CntClr  in  1  synchronous clear of FailCnt
- CondEx  out  1  qualified condition pass
- PCSrc  out  1  CondEx & PCS
- CtrlOut  out  CTRL_W  CtrlIn & {CTRL_W{CondEx}}, bit 0 additionally & ~NoWrite
- FlagsOut  out  4  live {N,Z,C,V} of Ctx (pre-update value)
- FailCnt  out  CNT_W  count of condition-failed instructions

## Operation
- RawEx decoded from Cond and live flags of Ctx: 0000 Z; 0001 ~Z; 0010 C; 0011 ~C; 0100 N; 0101 ~N; 0110 V; 0111 ~V; 1000 C&~Z; 1001 ~C|Z; 1010 N==V; 1011 N!=V; 1100 ~Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 0.
- Qual = Valid & ~Flush & ~Stall; CondEx = RawEx & Qual. All outputs except FlagsOut/FailCnt are gated by CondEx.
- Ctx or SRCtx >= NUM_CTX: treated as context 0.
- Instruction flag update at edge (when CondEx=1): FlagW[1] loads N,Z of bank Ctx from ALUFlags[3:2]; FlagW[0] loads C,V from ALUFlags[1:0]; unselected bits hold.
- Save/Restore act regardless of Valid/Stall/Flush. Save: shadow[SRCtx] <= live[SRCtx] (pre-edge value). Restore: live[SRCtx] <= shadow[SRCtx].
- Save and Restore same cycle: swap live and shadow of SRCtx.
- Restore and instruction update to same context same cycle: Restore wins for all four bits. Different contexts: both apply.
- FailCnt: increments when Qual=1 and RawEx=0; saturates at 2^CNT_W-1; CntClr has priority over increment (result 0).
- Other contexts' banks never change due to instruction activity.

## Timing
- Reset (RESETn low, async): all live and shadow flags 0, FailCnt 0; CondEx, PCSrc, CtrlOut forced 0 while RESETn low; FlagsOut 0.
- Decision latency 0: CondEx/PCSrc/CtrlOut combinational from inputs and current state.
- Flag update latency 1: an instruction's flags are visible to the instruction in the next cycle; no same-cycle forwarding.
- Stall: no flag update, no count; outputs 0; state held indefinitely.
- Reset asserted mid-update: async clear wins; no partial flag write.

## Test plan
- Reset, Ctx=0, Cond=0000, Valid=1 -> CondEx=0 (Z=0); Cond=1110 -> CondEx=1, PCSrc=PCS, CtrlOut=CtrlIn with bit0 cleared when NoWrite=1.
- Ctx=1, FlagW=11, ALUFlags=0100, Cond=1110 -> next cycle Ctx=1 Cond=0000 passes, Ctx=0 Cond=0000 fails, FlagsOut(ctx1)=0100.
- FlagW=10 with ALUFlags=1111 after C,V=10 -> bank becomes N,Z,C,V=1110.
- Save ctx2 (flags 1000), update to 0001, Restore ctx2 -> FlagsOut=1000; Save+Restore same cycle swaps; Restore vs instruction update on same ctx -> shadow value.
- Stall=1 or Flush=1 with Cond=1110, FlagW=11 -> all outputs 0, flags unchanged, FailCnt unchanged.
- CNT_W=2, four failing valid instructions -> FailCnt 1,2,3,3; CntClr with a fail same cycle -> 0.
